systolic_ctrl: RTL and testbench

Sequencer for the N x N systolic array of multiply-accumulate PEs. On a start request it clears the PE accumulators, runs the skewed operand wavefront for a runtime matrix size n (1..DIM), waits for the array to drain, then flags completion and aggregates the PE overflow/underflow flags. It sits between the host/register block and the operand feeder plus PE array; it drives no data itself, only timing and enables.

---
 rtl/systolic_ctrl.sv | 74 +++++++
 tb/tb_systolic_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences accumulator clear, skewed operand feed and drain for an NxN systolic MAC array
module systolic_ctrl #(
  parameter int DIM = 4,
  parameter int STEP_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [STEP_W-1:0]    dim_i,
  input  logic [DIM*DIM-1:0]   ouflow_i,
  output logic                 busy_o,
  output logic                 clr_o,
  output logic [DIM-1:0]       row_en_o,
  output logic [DIM-1:0]       col_en_o,
  output logic [STEP_W-1:0]    step_o,
  output logic                 done_o,
  output logic                 res_valid_o,
  output logic                 ouflow_o,
  output logic                 err_o
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [STEP_W-1:0] step, n;
  logic dim_ok, accept, of_any;
  // next state, wavefront lane enables and overflow reduction over the active n x n corner
  always_comb begin
    dim_ok = dim_i != '0 && dim_i <= STEP_W'(DIM);
    accept = state == IDLE && start_i && dim_ok;
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? CLEAR : IDLE;
      CLEAR:   state_nx = FEED;
      FEED:    state_nx = step == (n << 1) - STEP_W'(2) ? DRAIN : FEED;
      DRAIN:   state_nx = step == n * STEP_W'(3) - STEP_W'(2) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
    busy_o = state != IDLE;
    clr_o = state == CLEAR;
    done_o = state == DONE;
    step_o = (state == FEED || state == DRAIN) ? step : '0;
    row_en_o = '0;
    for (int i = 0; i < DIM; i++)
      row_en_o[i] = state == FEED && STEP_W'(i) < n && step >= STEP_W'(i) && step < STEP_W'(i) + n;
    col_en_o = row_en_o;
    of_any = 1'b0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        of_any = of_any | (ouflow_i[i*DIM+j] && STEP_W'(i) < n && STEP_W'(j) < n);
  end
  // state register
  always_ff @(posedge clk_i)
    state <= !rst_ni ? IDLE : state_nx;
  // step counter, latched run size, reject pulse and sticky result flags
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      step <= '0;
      n <= '0;
      res_valid_o <= 1'b0;
      ouflow_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      err_o <= state == IDLE && start_i && !dim_ok;
      step <= (state == FEED || state == DRAIN) ? step + STEP_W'(1) : '0;
      if (accept) begin
        n <= dim_i;
        res_valid_o <= 1'b0;
        ouflow_o <= 1'b0;
      end else if (state == DONE) begin
        res_valid_o <= 1'b1;
        ouflow_o <= of_any;
      end
    end
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: scoreboard bench for the systolic sequencer with a small feeder + PE array model
module tb_systolic_ctrl;
  logic clk = 1'b0;
  logic rst_ni, start_i;
  logic [7:0] dim_i;
  logic [15:0] ouflow_i;
  logic busy_o, clr_o, done_o, res_valid_o, ouflow_o, err_o;
  logic [3:0] row_en_o, col_en_o;
  logic [7:0] step_o;
  int checks = 0;
  int errors = 0;
  logic [21:0] v_q[$];
  string t_q[$];
  int res_q[$];
  logic cur_rv, cur_of;
  int amat[4][4];
  int bmat[4][4];
  int a_r[4][4];
  int b_r[4][4];
  int acc[4][4];

  systolic_ctrl #(.DIM(4), .STEP_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .dim_i(dim_i), .ouflow_i(ouflow_i),
    .busy_o(busy_o), .clr_o(clr_o), .row_en_o(row_en_o), .col_en_o(col_en_o), .step_o(step_o),
    .done_o(done_o), .res_valid_o(res_valid_o), .ouflow_o(ouflow_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic int ain(int i, int j);
    int k;
    if (j != 0) return a_r[i][j-1];
    k = int'(step_o) - i;
    return (row_en_o[i] && k >= 0 && k < 4) ? amat[i][k] : 0;
  endfunction

  function automatic int bin(int i, int j);
    int k;
    if (i != 0) return b_r[i-1][j];
    k = int'(step_o) - j;
    return (col_en_o[j] && k >= 0 && k < 4) ? bmat[k][j] : 0;
  endfunction

  // operand-stationary-free output-stationary array fed by the DUT enables
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc[i][j] <= clr_o ? 0 : acc[i][j] + ain(i, j) * bin(i, j);
        a_r[i][j] <= clr_o ? 0 : ain(i, j);
        b_r[i][j] <= clr_o ? 0 : bin(i, j);
      end

  // monitor: pop one expected output vector per cycle, and PE results on done
  always @(negedge clk) begin
    logic [21:0] got, e;
    string t;
    if (v_q.size() > 0) begin
      e = v_q.pop_front();
      t = t_q.pop_front();
      got = {busy_o, clr_o, row_en_o, col_en_o, step_o, done_o, res_valid_o, ouflow_o, err_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h (busy,clr,row,col,step,done,rv,of,err)", t, got, e);
      end
    end
    if (done_o && res_q.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        int r;
        r = res_q.pop_front();
        checks++;
        if (acc[k/2][k%2] != r) begin
          errors++;
          $display("FAIL pe_result(%0d,%0d) got=%0d exp=%0d", k/2, k%2, acc[k/2][k%2], r);
        end
      end
  end

  function automatic logic [21:0] mk(logic busy, logic clr, logic [3:0] en, int s, logic done, logic rv, logic of, logic err);
    return {busy, clr, en, en, 8'(s), done, rv, of, err};
  endfunction

  function automatic logic [3:0] en_exp(int n, int s);
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = i < n && s >= i && s < i + n;
    return e;
  endfunction

  task automatic tick(input logic [21:0] v, input string t);
    @(posedge clk);
    #1;
    v_q.push_back(v);
    t_q.push_back(t);
  endtask

  task automatic idle(input string t);
    tick(mk(0, 0, 4'h0, 0, 0, cur_rv, cur_of, 0), t);
  endtask

  task automatic do_run(input int n, input logic exp_of, input logic keep);
    start_i = 1'b1;
    dim_i = 8'(n);
    tick(mk(1, 1, 4'h0, 0, 0, 0, 0, 0), "clear");
    if (!keep) dim_i = 8'd9;
    for (int s = 0; s <= 2*n-2; s++) tick(mk(1, 0, en_exp(n, s), s, 0, 0, 0, 0), "feed");
    for (int s = 2*n-1; s <= 3*n-2; s++) tick(mk(1, 0, 4'h0, s, 0, 0, 0, 0), "drain");
    tick(mk(1, 0, 4'h0, 0, 1, 0, 0, 0), "done");
    if (!keep) start_i = 1'b0;
    cur_rv = 1'b1;
    cur_of = exp_of;
  endtask

  task automatic err_try(input int d);
    start_i = 1'b1;
    dim_i = 8'(d);
    tick(mk(0, 0, 4'h0, 0, 0, cur_rv, cur_of, 1), "err_pulse");
    start_i = 1'b0;
    idle("err_end");
  endtask

  task automatic push_res();
    res_q.push_back(19);
    res_q.push_back(22);
    res_q.push_back(43);
    res_q.push_back(50);
  endtask

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0;
    dim_i = '0;
    ouflow_i = '0;
    cur_rv = 1'b0;
    cur_of = 1'b0;
    amat[0][0] = 1; amat[0][1] = 2; amat[1][0] = 3; amat[1][1] = 4;
    bmat[0][0] = 5; bmat[0][1] = 6; bmat[1][0] = 7; bmat[1][1] = 8;
    tick(mk(0, 0, 4'h0, 0, 0, 0, 0, 0), "reset");
    tick(mk(0, 0, 4'h0, 0, 0, 0, 0, 0), "reset");
    rst_ni = 1'b1;
    idle("idle");
    do_run(4, 0, 0);
    idle("res_n4");
    push_res();
    do_run(2, 0, 0);
    idle("res_n2");
    ouflow_i = 16'h0040;
    do_run(3, 1, 0);
    idle("of_pe12");
    err_try(0);
    err_try(5);
    ouflow_i = 16'h9008;
    do_run(3, 0, 0);
    idle("of_masked");
    ouflow_i = '0;
    start_i = 1'b1;
    dim_i = 8'd4;
    tick(mk(1, 1, 4'h0, 0, 0, 0, 0, 0), "clear");
    start_i = 1'b0;
    for (int s = 0; s <= 3; s++) tick(mk(1, 0, en_exp(4, s), s, 0, 0, 0, 0), "feed");
    rst_ni = 1'b0;
    cur_rv = 1'b0;
    cur_of = 1'b0;
    tick(mk(0, 0, 4'h0, 0, 0, 0, 0, 0), "abort");
    rst_ni = 1'b1;
    idle("post_abort");
    idle("post_abort");
    push_res();
    do_run(2, 0, 0);
    idle("res_after_abort");
    for (int k = 0; k < 3; k++) begin
      do_run(1, 0, 1);
      idle("b2b_gap");
    end
    start_i = 1'b0;
    idle("tail");
    idle("tail");
    @(negedge clk);
    #1;
    checks++;
    if (v_q.size() != 0 || res_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d pending exp=0/0", v_q.size(), res_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
